// File: rtl/car_sensor_driver_if.sv
// Command handshake and emulated sensor outputs of the car sensor driver.
// The master issues enter/exit commands and the slave drives the beam sensors.
interface car_sensor_driver_if;
    logic       cmd_valid;
    logic       cmd_dir;
    logic       cmd_ready;
    logic       sensor_a;
    logic       sensor_b;
    logic       busy;
    logic       done;
    logic [2:0] model_count;

    modport master (
        output cmd_valid,
        output cmd_dir,
        input  cmd_ready,
        input  sensor_a,
        input  sensor_b,
        input  busy,
        input  done,
        input  model_count
    );

    modport slave (
        input  cmd_valid,
        input  cmd_dir,
        output cmd_ready,
        output sensor_a,
        output sensor_b,
        output busy,
        output done,
        output model_count
    );
endinterface

// File: rtl/car_sensor_driver.sv
// Emulates the two beam sensors of a car passing a gate (enter or exit) and
// keeps the reference occupancy count the lot counter is checked against.
module car_sensor_driver #(
    parameter int unsigned HOLD_CYCLES = 1,
    parameter int unsigned GAP_CYCLES  = 1
) (
    input logic                 clk,
    input logic                 reset,
    car_sensor_driver_if.slave  bus
);
    typedef enum logic [2:0] {StIdle, StPh1, StPh2, StPh3, StGap} state_e;

    localparam logic [7:0] HoldLoad = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] GapLoad  = 8'(GAP_CYCLES - 1);

    state_e     state_q, state_d;
    logic [7:0] hold_q, hold_d;
    logic       dir_q, dir_d;
    logic [2:0] count_q, count_d;
    logic       a_q, a_d, b_q, b_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        dir_d   = dir_q;
        count_d = count_q;
        case (state_q)
            StIdle: begin
                if (bus.cmd_valid) begin
                    state_d = StPh1;
                    dir_d   = bus.cmd_dir;
                end
            end
            StPh1: if (hold_q == 8'd0) state_d = StPh2; else hold_d = hold_q - 8'd1;
            StPh2: if (hold_q == 8'd0) state_d = StPh3; else hold_d = hold_q - 8'd1;
            StPh3: if (hold_q == 8'd0) state_d = StGap; else hold_d = hold_q - 8'd1;
            StGap: begin
                if (hold_q == 8'd0) begin
                    state_d = StIdle;
                    // Saturating update: full pattern is still emitted at the limits.
                    if (!dir_q && count_q != 3'd7) count_d = count_q + 3'd1;
                    if (dir_q && count_q != 3'd0)  count_d = count_q - 3'd1;
                end else begin
                    hold_d = hold_q - 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_d != state_q) begin
            case (state_d)
                StGap:   hold_d = GapLoad;
                StIdle:  hold_d = 8'd0;
                default: hold_d = HoldLoad;
            endcase
        end
    end

    // Sensor levels decoded from the next state so the outputs come straight from flops.
    always_comb begin
        a_d = 1'b0;
        b_d = 1'b0;
        case (state_d)
            StPh1:   begin a_d = ~dir_d; b_d = dir_d;  end
            StPh2:   begin a_d = 1'b1;   b_d = 1'b1;   end
            StPh3:   begin a_d = dir_d;  b_d = ~dir_d; end
            default: begin a_d = 1'b0;   b_d = 1'b0;   end
        endcase
        busy_d = (state_d != StIdle);
        done_d = (state_q == StGap) && (state_d == StIdle);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            hold_q  <= 8'd0;
            dir_q   <= 1'b0;
            count_q <= 3'd0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            dir_q   <= dir_d;
            count_q <= count_d;
            a_q     <= a_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.cmd_ready   = (state_q == StIdle) && !reset;
    assign bus.sensor_a    = a_q;
    assign bus.sensor_b    = b_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.model_count = count_q;
endmodule

// File: doc/car_sensor_driver.md
CAR_SENSOR_DRIVER -- requirements
Module: car_sensor_driver

Interface
REQ-001 Parameter HOLD_CYCLES, default 1, clock cycles each sensor phase is held; legal range 1..255.
REQ-002 Parameter GAP_CYCLES, default 1, cycles of a=0,b=0 after the third phase; legal range 1..255.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 cmd_valid  input  1  command offered this cycle.
REQ-006 cmd_dir  input  1  command direction: 0 = car enters, 1 = car exits.
REQ-007 cmd_ready  output  1  driver can accept a command this cycle.
REQ-008 sensor_a  output  1  emulated outer beam sensor, registered.
REQ-009 sensor_b  output  1  emulated inner beam sensor, registered.
REQ-010 busy  output  1  a sensor sequence is in progress.
REQ-011 done  output  1  one-cycle pulse when a sequence completes.
REQ-012 model_count  output  3  reference occupancy the lot counter must match, 0..7.

Function
REQ-013 FSM states SHALL be IDLE, PH1, PH2, PH3 and GAP.
REQ-014 cmd_ready SHALL equal 1 exactly when the state is IDLE and reset is low.
REQ-015 A command SHALL be accepted on a rising edge where cmd_valid=1 and cmd_ready=1; cmd_dir is latched on that edge only.
REQ-016 Acceptance SHALL move IDLE->PH1; sensor outputs SHALL show the PH1 pattern in the first cycle after acceptance.
REQ-017 Enter patterns (a,b) SHALL be PH1=(1,0), PH2=(1,1), PH3=(0,1).
REQ-018 Exit patterns (a,b) SHALL be PH1=(0,1), PH2=(1,1), PH3=(1,0).
REQ-019 Each of PH1, PH2 and PH3 SHALL last exactly HOLD_CYCLES cycles; an internal 8-bit hold counter reloads on every state change.
REQ-020 GAP SHALL drive (0,0) for exactly GAP_CYCLES cycles, then return to IDLE.
REQ-021 In IDLE, sensor outputs SHALL be (0,0).
REQ-022 busy SHALL be 1 in PH1, PH2, PH3 and GAP, and 0 in IDLE.
REQ-023 done SHALL be 1 for exactly the first IDLE cycle after GAP.
REQ-024 model_count SHALL update on the edge that enters that IDLE cycle, so the new value is visible in the same cycle done=1.
REQ-025 Enter update: model_count +1, saturating at 7; enter at 7 still emits the full pattern and the count stays 7.
REQ-026 Exit update: model_count -1, floored at 0; exit at 0 still emits the full pattern and the count stays 0.
REQ-027 A new command MAY be accepted in the same cycle done=1, giving back-to-back sequences with one IDLE cycle between them.
REQ-028 Sequence length from the acceptance edge to the done cycle SHALL be 3*HOLD_CYCLES + GAP_CYCLES + 1 cycles.
REQ-029 cmd_valid and cmd_dir changes while busy=1 SHALL be ignored; there is no command queue.
REQ-030 A sensor output SHALL never change more than once per cycle; no glitching combinational path to sensor_a or sensor_b.

Reset
REQ-031 reset=1 SHALL force, asynchronously: state IDLE, sensor_a=0, sensor_b=0, busy=0, done=0, model_count=0, hold counter 0.
REQ-032 reset asserted mid-sequence SHALL abandon the sequence with no model_count update and no done pulse.
REQ-033 cmd_ready SHALL be 0 while reset=1, and 1 in the first cycle after reset deasserts.

Verification
REQ-034 Defaults, one enter command after reset -> (a,b) = 10, 11, 01, 00 on consecutive cycles, then done=1 with model_count=1.
REQ-035 Defaults, two enters then three exits back-to-back -> exit pattern is 01, 11, 10, 00; model_count goes 1,2,1,0,0 and the third exit still drives its full pattern.
REQ-036 Defaults, eight consecutive enters -> model_count goes 1..7, then stays 7 after the eighth; eight done pulses total.
REQ-037 HOLD_CYCLES=3, GAP_CYCLES=2, one exit -> each phase lasts 3 cycles, gap lasts 2, done exactly 12 cycles after the acceptance edge.
REQ-038 reset pulsed during PH2 of an enter -> outputs 00 immediately, model_count=0, no done pulse, cmd_ready=1 the cycle after reset deasserts.
REQ-039 cmd_valid=1 held with cmd_dir toggled every cycle during a sequence -> exactly one sequence in progress, its direction fixed at acceptance, and the next command accepted only in the done cycle.
